// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the regfile_sp register file.
//   - default width and depth constants
//   - all-ones stack pointer reset default (sliced to WIDTH by the user)
//   - clog2 helper for address width derivation
//   - sp_op_t: resolved stack pointer operation and its resolver
package regfile_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;

   // Wide all-ones pattern; users slice the low WIDTH bits.
   localparam logic [255:0] DEF_SP_RESET = '1;

   typedef enum logic [1:0] {
      SP_HOLD,
      SP_INC,
      SP_DEC,
      SP_LOAD
   } sp_op_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // A direct write to the SP entry beats push/pop. Simultaneous push and
   // pop cancel out.
   function automatic sp_op_t resolve_sp_op(input logic inc, input logic dec,
                                            input logic load);
      if (load)
         return SP_LOAD;
      if (inc && !dec)
         return SP_INC;
      if (dec && !inc)
         return SP_DEC;
      return SP_HOLD;
   endfunction

endpackage

// File: rtl/regfile_sp_ctrl.sv
// regfile_sp_ctrl: stack pointer control for regfile_sp.
// Resolves push/pop/load into one operation, computes the next SP value
// (modulo 2^WIDTH) and generates the registered wrap flags.
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous reset, active low (clears the flags)
//   inc        pop request (SP + 1)
//   dec        push request (SP - 1)
//   load       write port targets the SP entry this cycle
//   load_data  value written when load is set
//   sp         current SP register contents
//   sp_next    value the SP register takes at the next edge
//   ovf        one-cycle pulse after an increment wrapped all-ones -> 0
//   unf        one-cycle pulse after a decrement wrapped 0 -> all-ones
module regfile_sp_ctrl
   import regfile_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic [WIDTH-1:0] sp,
   output logic [WIDTH-1:0] sp_next,
   output logic             ovf,
   output logic             unf
);

   sp_op_t op;
   logic   ovf_p1;
   logic   unf_p1;

   always_comb begin
      op      = resolve_sp_op(inc, dec, load);
      sp_next = sp;
      case (op)
         SP_INC:  sp_next = sp + 1'b1;
         SP_DEC:  sp_next = sp - 1'b1;
         SP_LOAD: sp_next = load_data;
         default: sp_next = sp;
      endcase
   end

   // ---- stage p1: wrap flags, valid for exactly the cycle after the update
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_p1 <= 1'b0;
         unf_p1 <= 1'b0;
      end else begin
         ovf_p1 <= (op == SP_INC) && (sp == '1);
         unf_p1 <= (op == SP_DEC) && (sp == '0);
      end
   end

   assign ovf = ovf_p1;
   assign unf = unf_p1;

endmodule

// File: rtl/regfile_sp.sv
// regfile_sp: parametrised register file with one write port, two
// registered read ports (1-cycle latency) and a stack pointer entry at
// SP_IDX with hardware push/pop.
// Optional feature: define REGFILE_WRITE_BYPASS_EN to forward WrData to a
// read port whose address matches the in-range write address in the same
// cycle. Without it, reads return the pre-edge contents.
// Ports:
//   CLK         clock, rising edge
//   RST         synchronous reset, active low
//   WrEn        write enable
//   W_Add       write address
//   WrData      write data
//   RdEn        read request for both read ports
//   R_Add_A     read address, port A
//   R_Add_B     read address, port B
//   SpInc       stack pointer +1 (pop)
//   SpDec       stack pointer -1 (push)
//   REGA        registered read data, port A
//   REGB        registered read data, port B
//   RdData_VLD  REGA/REGB updated this cycle
//   Sp          live stack pointer (SP_IDX entry)
//   SpOvf       one-cycle pulse after an all-ones -> 0 increment
//   SpUnf       one-cycle pulse after a 0 -> all-ones decrement
module regfile_sp
   import regfile_pkg::*;
#(
   parameter int               WIDTH    = DEF_WIDTH,
   parameter int               DEPTH    = DEF_DEPTH,
   parameter int               ADDR     = clog2(DEPTH),
   parameter int               SP_IDX   = DEPTH - 1,
   parameter logic [WIDTH-1:0] SP_RESET = DEF_SP_RESET[WIDTH-1:0]
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             WrEn,
   input  logic [ADDR-1:0]  W_Add,
   input  logic [WIDTH-1:0] WrData,
   input  logic             RdEn,
   input  logic [ADDR-1:0]  R_Add_A,
   input  logic [ADDR-1:0]  R_Add_B,
   input  logic             SpInc,
   input  logic             SpDec,
   output logic [WIDTH-1:0] REGA,
   output logic [WIDTH-1:0] REGB,
   output logic             RdData_VLD,
   output logic [WIDTH-1:0] Sp,
   output logic             SpOvf,
   output logic             SpUnf
);

   // One extra bit so DEPTH = 2^ADDR is representable in the range compare.
   localparam logic [ADDR:0]   DEPTH_L = DEPTH[ADDR:0];
   localparam logic [ADDR-1:0] SP_ADDR = ADDR'(SP_IDX);

   logic [WIDTH-1:0] mem [DEPTH];

   logic             w_ok;
   logic             a_ok;
   logic             b_ok;
   logic             sp_load;
   logic [WIDTH-1:0] sp_next;
   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;

   logic [WIDTH-1:0] rega_p1;
   logic [WIDTH-1:0] regb_p1;
   logic             vld_p1;

   assign w_ok    = {1'b0, W_Add}   < DEPTH_L;
   assign a_ok    = {1'b0, R_Add_A} < DEPTH_L;
   assign b_ok    = {1'b0, R_Add_B} < DEPTH_L;
   assign sp_load = WrEn && (W_Add == SP_ADDR);
   assign Sp      = mem[SP_IDX];

   regfile_sp_ctrl #(
      .WIDTH (WIDTH)
   ) u_ctrl (
      .clk       (CLK),
      .rst_n     (RST),
      .inc       (SpInc),
      .dec       (SpDec),
      .load      (sp_load),
      .load_data (WrData),
      .sp        (mem[SP_IDX]),
      .sp_next   (sp_next),
      .ovf       (SpOvf),
      .unf       (SpUnf)
   );

   always_comb begin
      rd_a = a_ok ? mem[R_Add_A] : '0;
      rd_b = b_ok ? mem[R_Add_B] : '0;
`ifdef REGFILE_WRITE_BYPASS_EN
      if (WrEn && w_ok && (R_Add_A == W_Add))
         rd_a = WrData;
      if (WrEn && w_ok && (R_Add_B == W_Add))
         rd_b = WrData;
`endif
   end

   // ---- storage: SP entry follows the controller, others take the write port
   always_ff @(posedge CLK) begin
      if (!RST) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i == SP_IDX)
               mem[i] <= sp_next;
            else if (WrEn && w_ok && (W_Add == ADDR'(i)))
               mem[i] <= WrData;
         end
      end
   end

   // ---- stage p1: registered read ports
   always_ff @(posedge CLK) begin
      if (!RST) begin
         rega_p1 <= '0;
         regb_p1 <= '0;
         vld_p1  <= 1'b0;
      end else begin
         vld_p1 <= RdEn;
         if (RdEn) begin
            rega_p1 <= rd_a;
            regb_p1 <= rd_b;
         end
      end
   end

   assign REGA       = rega_p1;
   assign REGB       = regb_p1;
   assign RdData_VLD = vld_p1;

endmodule

// File: tb/tb_regfile_sp.sv
// tb_regfile_sp: directed, table-driven bench for regfile_sp with default
// parameters (WIDTH=8, DEPTH=4, SP_IDX=3, SP_RESET=8'hFF). Each table row
// is driven for one cycle and the outputs are compared just after the edge.
module tb_regfile_sp;

   logic       CLK;
   logic       RST;
   logic       WrEn;
   logic [1:0] W_Add;
   logic [7:0] WrData;
   logic       RdEn;
   logic [1:0] R_Add_A;
   logic [1:0] R_Add_B;
   logic       SpInc;
   logic       SpDec;
   logic [7:0] REGA;
   logic [7:0] REGB;
   logic       RdData_VLD;
   logic [7:0] Sp;
   logic       SpOvf;
   logic       SpUnf;

   int checks = 0;
   int errors = 0;

`ifdef REGFILE_WRITE_BYPASS_EN
   localparam int RDW_R0 = 'h22;
   localparam int RDW_SP = 'h40;
`else
   localparam int RDW_R0 = 'h11;
   localparam int RDW_SP = 'h81;
`endif

   typedef struct {
      logic       wr;
      logic [1:0] wa;
      logic [7:0] wd;
      logic       rd;
      logic [1:0] ra;
      logic [1:0] rb;
      logic       inc;
      logic       dec;
      logic [7:0] ea;
      logic [7:0] eb;
      logic       ev;
      logic [7:0] esp;
      logic       eovf;
      logic       eunf;
   } vec_t;

   localparam int NV = 21;
   vec_t tbl [NV];

   regfile_sp dut (
      .CLK        (CLK),
      .RST        (RST),
      .WrEn       (WrEn),
      .W_Add      (W_Add),
      .WrData     (WrData),
      .RdEn       (RdEn),
      .R_Add_A    (R_Add_A),
      .R_Add_B    (R_Add_B),
      .SpInc      (SpInc),
      .SpDec      (SpDec),
      .REGA       (REGA),
      .REGB       (REGB),
      .RdData_VLD (RdData_VLD),
      .Sp         (Sp),
      .SpOvf      (SpOvf),
      .SpUnf      (SpUnf)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic vec_t mk(input int wr, input int wa, input int wd,
                               input int rd, input int ra, input int rb,
                               input int inc, input int dec,
                               input int ea, input int eb, input int ev,
                               input int esp, input int eovf, input int eunf);
      vec_t v;
      v.wr   = wr[0];
      v.wa   = wa[1:0];
      v.wd   = wd[7:0];
      v.rd   = rd[0];
      v.ra   = ra[1:0];
      v.rb   = rb[1:0];
      v.inc  = inc[0];
      v.dec  = dec[0];
      v.ea   = ea[7:0];
      v.eb   = eb[7:0];
      v.ev   = ev[0];
      v.esp  = esp[7:0];
      v.eovf = eovf[0];
      v.eunf = eunf[0];
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input vec_t v);
      RST     = rst;
      WrEn    = v.wr;
      W_Add   = v.wa;
      WrData  = v.wd;
      RdEn    = v.rd;
      R_Add_A = v.ra;
      R_Add_B = v.rb;
      SpInc   = v.inc;
      SpDec   = v.dec;
   endtask

   task automatic check_outs(input string tag, input vec_t v);
      chk({tag, " REGA"},       REGA,              v.ea);
      chk({tag, " REGB"},       REGB,              v.eb);
      chk({tag, " RdData_VLD"}, {7'd0, RdData_VLD}, {7'd0, v.ev});
      chk({tag, " Sp"},         Sp,                v.esp);
      chk({tag, " SpOvf"},      {7'd0, SpOvf},     {7'd0, v.eovf});
      chk({tag, " SpUnf"},      {7'd0, SpUnf},     {7'd0, v.eunf});
   endtask

   initial begin
      vec_t idle;
      vec_t v;
      //          wr wa wd    rd ra rb inc dec | ea     eb    ev esp   ovf unf
      tbl[0]  = mk(0, 0, 0,    1, 1, 2, 0, 0,   'h00,  'h00, 1, 'hFF, 0, 0);
      tbl[1]  = mk(1, 1, 'h3C, 0, 0, 0, 0, 0,   'h00,  'h00, 0, 'hFF, 0, 0);
      tbl[2]  = mk(1, 2, 'hA5, 0, 0, 0, 0, 0,   'h00,  'h00, 0, 'hFF, 0, 0);
      tbl[3]  = mk(0, 0, 0,    1, 1, 2, 0, 0,   'h3C,  'hA5, 1, 'hFF, 0, 0);
      tbl[4]  = mk(0, 0, 0,    0, 0, 0, 0, 0,   'h3C,  'hA5, 0, 'hFF, 0, 0);
      tbl[5]  = mk(0, 0, 0,    1, 3, 0, 0, 0,   'hFF,  'h00, 1, 'hFF, 0, 0);
      tbl[6]  = mk(0, 0, 0,    0, 0, 0, 1, 0,   'hFF,  'h00, 0, 'h00, 1, 0);
      tbl[7]  = mk(0, 0, 0,    0, 0, 0, 0, 0,   'hFF,  'h00, 0, 'h00, 0, 0);
      tbl[8]  = mk(0, 0, 0,    0, 0, 0, 0, 1,   'hFF,  'h00, 0, 'hFF, 0, 1);
      tbl[9]  = mk(0, 0, 0,    0, 0, 0, 0, 0,   'hFF,  'h00, 0, 'hFF, 0, 0);
      tbl[10] = mk(0, 0, 0,    0, 0, 0, 1, 1,   'hFF,  'h00, 0, 'hFF, 0, 0);
      tbl[11] = mk(0, 0, 0,    0, 0, 0, 0, 1,   'hFF,  'h00, 0, 'hFE, 0, 0);
      tbl[12] = mk(0, 0, 0,    0, 0, 0, 1, 0,   'hFF,  'h00, 0, 'hFF, 0, 0);
      tbl[13] = mk(0, 0, 0,    0, 0, 0, 1, 0,   'hFF,  'h00, 0, 'h00, 1, 0);
      tbl[14] = mk(1, 3, 'h80, 0, 0, 0, 0, 1,   'hFF,  'h00, 0, 'h80, 0, 0);
      tbl[15] = mk(1, 0, 'h11, 0, 0, 0, 0, 0,   'hFF,  'h00, 0, 'h80, 0, 0);
      tbl[16] = mk(1, 0, 'h22, 1, 0, 3, 0, 0,   RDW_R0,'h80, 1, 'h80, 0, 0);
      tbl[17] = mk(0, 0, 0,    1, 0, 3, 1, 0,   'h22,  'h80, 1, 'h81, 0, 0);
      tbl[18] = mk(1, 3, 'h40, 1, 3, 3, 1, 0,   RDW_SP,RDW_SP,1,'h40, 0, 0);
      tbl[19] = mk(0, 0, 0,    1, 1, 2, 0, 0,   'h3C,  'hA5, 1, 'h40, 0, 0);
      tbl[20] = mk(0, 0, 0,    1, 2, 1, 0, 0,   'hA5,  'h3C, 1, 'h40, 0, 0);

      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset held for two edges
      drive(1'b0, idle);
      repeat (2) @(posedge CLK);
      #1;
      check_outs("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 'h00, 'h00, 0, 'hFF, 0, 0));

      for (int i = 0; i < NV; i++) begin
         drive(1'b1, tbl[i]);
         @(posedge CLK);
         #1;
         check_outs($sformatf("row%0d", i), tbl[i]);
      end

      // Reset in the same cycle as a write, a push and a read: all aborted
      v = mk(1, 1, 'h55, 1, 1, 2, 0, 1, 'h00, 'h00, 0, 'hFF, 0, 0);
      drive(1'b0, v);
      @(posedge CLK);
      #1;
      check_outs("midrst", v);

      // First cycle after release is normal; R1/R2 were cleared
      v = mk(0, 0, 0, 1, 1, 2, 0, 0, 'h00, 'h00, 1, 'hFF, 0, 0);
      drive(1'b1, v);
      @(posedge CLK);
      #1;
      check_outs("postrst_rd", v);

      v = mk(0, 0, 0, 0, 0, 0, 0, 1, 'h00, 'h00, 0, 'hFE, 0, 0);
      drive(1'b1, v);
      @(posedge CLK);
      #1;
      check_outs("postrst_dec", v);

      drive(1'b1, idle);
      @(posedge CLK);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_sp.md
Name: regfile_sp

Overview:
Parametrised register file for the pipelined datapath: one write port, two registered read ports, and a dedicated stack-pointer entry with hardware push/pop (increment/decrement). It sits between the decode stage and the ALU/address unit. It supplies REGA/REGB operands one cycle after a read request, and always exposes the live stack pointer to the memory stage.

Parameters:
WIDTH, 8, data width of each register
DEPTH, 4, number of registers (2..256)
ADDR, 2, address width; must equal clog2(DEPTH)
SP_IDX, DEPTH-1, index of the register used as stack pointer
SP_RESET, 2^WIDTH-1, stack pointer value loaded at reset

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous reset, active low
WrEn  input  1  write enable
W_Add  input  ADDR  write address
WrData  input  WIDTH  write data
RdEn  input  1  read request for both read ports
R_Add_A  input  ADDR  read address, port A
R_Add_B  input  ADDR  read address, port B
SpInc  input  1  stack pointer +1 (pop)
SpDec  input  1  stack pointer -1 (push)
REGA  output  WIDTH  registered read data, port A
REGB  output  WIDTH  registered read data, port B
RdData_VLD  output  1  REGA/REGB updated this cycle
Sp  output  WIDTH  current stack pointer, direct from the SP_IDX register
SpOvf  output  1  one-cycle pulse: SP wrapped all-ones -> 0 on SpInc
SpUnf  output  1  one-cycle pulse: SP wrapped 0 -> all-ones on SpDec

Behaviour:
- One clock CLK. Reset is synchronous and active-low on RST. Every register and output updates only on the CLK rising edge.
- Reset (RST=0 at the edge):
  - every entry is set to 0, except entry SP_IDX, which is set to SP_RESET;
  - REGA=0, REGB=0, RdData_VLD=0, SpOvf=0, SpUnf=0;
  - all other inputs are ignored in that cycle.
- Reset asserted mid-operation aborts any pending write, read or SP update. The first cycle after reset release is a normal cycle.
- Read path:
  - RdEn=1 at edge N: REGA/REGB capture the addressed entries and RdData_VLD=1 after edge N (1-cycle latency).
  - RdEn=0: REGA/REGB hold their previous values and RdData_VLD=0.
  - Back-to-back RdEn gives a new result every cycle.
- Write path: WrEn=1 writes WrData to entry W_Add at the edge.
- Out-of-range addresses (address >= DEPTH, possible only when DEPTH is not a power of two): the write is dropped and the read returns 0.
- Read-during-write to the same address: a read returns the pre-edge contents (no forwarding), unless WRITE_BYPASS_EN is defined.
- Stack pointer:
  - SpInc alone: SP <= SP+1, modulo 2^WIDTH.
  - SpDec alone: SP <= SP-1, modulo 2^WIDTH.
  - SpInc and SpDec together: SP unchanged, no flags.
  - WrEn with W_Add=SP_IDX in the same cycle as SpInc/SpDec: the write wins, SP is loaded with WrData, and no flag pulses.
- Overflow/underflow flags:
  - SpOvf=1 for exactly one cycle after an increment from all-ones.
  - SpUnf=1 for exactly one cycle after a decrement from 0.
  - Both flags are 0 in all other cycles.
- Sp reflects the SP_IDX register with no extra latency. It changes on the same edge as the register.
- A read of SP_IDX in the same cycle as SpInc/SpDec returns the pre-update SP value.

Optional Feature:
Macro REGFILE_WRITE_BYPASS_EN.
- Defined: when RdEn=1, WrEn=1 and a read address equals W_Add (in range), that port captures WrData instead of the stored value. This includes SP_IDX writes, and WrData is still returned if SpInc/SpDec is also active.
- Not defined: no forwarding; the read returns the old contents. No extra logic is synthesised.

Decomposition:
- Shared package regfile_pkg holds:
  - default WIDTH/DEPTH constants;
  - a clog2 function;
  - the SP_RESET default;
  - an sp_op enum {SP_HOLD, SP_INC, SP_DEC, SP_LOAD}, resolved from SpInc/SpDec/WrEn with the priority above.
- One sub-module, regfile_sp_ctrl, is natural. It handles SP op resolution, the modulo increment/decrement and the flag pulse generation. The storage array and read ports stay in regfile_sp.

Test Plan:
- Reset: drive RST=0 for 2 cycles, then release -> Sp=8'hFF, REGA=REGB=0, RdData_VLD=0, reading R1/R2 returns 0.
- Write/read: write R1=8'h3C, R2=8'hA5; RdEn with A=1, B=2 -> one cycle later REGA=8'h3C, REGB=8'hA5, RdData_VLD=1 for one cycle only.
- Stack wrap:
  - SpInc at Sp=8'hFF -> Sp=8'h00, SpOvf pulses 1 cycle.
  - SpDec at 8'h00 -> Sp=8'hFF, SpUnf pulses 1 cycle.
  - SpInc+SpDec together -> Sp unchanged, no flags.
- SP priority: WrEn, W_Add=3, WrData=8'h80, with SpDec, at Sp=8'h00 -> Sp=8'h80, SpUnf=0.
- Read-during-write: R0=8'h11; write R0=8'h22 with RdEn, A=0 -> REGA=8'h11 without the macro, 8'h22 with REGFILE_WRITE_BYPASS_EN.
- Sync reset mid-op: RST=0 in the same cycle as WrEn R1=8'h55 and SpDec -> R1=0, Sp=8'hFF, RdData_VLD=0 afterwards.
